product_bcd_conv: RTL and testbench



---
 rtl/product_bcd_conv_pkg.sv | 39 +++
 rtl/product_bcd_conv_add3.sv | 15 +
 rtl/product_bcd_conv.sv | 144 ++++++++++++++
 tb/tb_product_bcd_conv.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/product_bcd_conv_pkg.sv
`default_nettype none
// ============================================================================
// Module : product_bcd_pkg
// Desc   : Shared constants, state encoding and 7-segment patterns for the
//          product_bcd_conv binary-to-BCD converter.
// Rev    : 1.0  initial release
// ============================================================================
package product_bcd_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_DIGITS = 5;

   typedef logic [0:0] state_t;
   localparam state_t IDLE = 1'b0;
   localparam state_t CONV = 1'b1;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // {a,b,c,d,e,f,g}, active-high
   function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'b1111110;
         4'd1:    seg = 7'b0110000;
         4'd2:    seg = 7'b1101101;
         4'd3:    seg = 7'b1111001;
         4'd4:    seg = 7'b0110011;
         4'd5:    seg = 7'b1011011;
         4'd6:    seg = 7'b1011111;
         4'd7:    seg = 7'b1110000;
         4'd8:    seg = 7'b1111111;
         4'd9:    seg = 7'b1111011;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage
`default_nettype wire

// File: rtl/product_bcd_conv_add3.sv
`default_nettype none
// ============================================================================
// Module : bcd_add3
// Desc   : Double-dabble digit correction: adds 3 when the digit is >= 5.
// Rev    : 1.0  initial release
// ============================================================================
module bcd_add3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule
`default_nettype wire

// File: rtl/product_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module : product_bcd_conv
// Desc   : Sequential shift-and-add-3 binary-to-BCD converter, one bit per
//          clock, with a one-entry pending buffer for back-to-back products.
//          Optional macro PRODUCT_BCD_SEG_EN adds a registered 7-segment output.
// Rev    : 1.0  initial release
// ============================================================================
module product_bcd_conv
   import product_bcd_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DIGITS = DEF_DIGITS
) (
   input  logic                  clk,
   input  logic                  reset_a,
   input  logic                  done_flag,
   input  logic [WIDTH-1:0]      product_in,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  bcd_valid,
   output logic                  busy,
   output logic                  overrun
`ifdef PRODUCT_BCD_SEG_EN
   ,
   output logic [7*DIGITS-1:0]   seg_out
`endif
);

   localparam int                c_cnt_w = $clog2(WIDTH);
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

   state_t                r_state;
   logic [WIDTH-1:0]      r_bin_sr;
   logic [4*DIGITS-1:0]   r_acc;
   logic [c_cnt_w-1:0]    r_cnt;
   logic [WIDTH-1:0]      r_pend_data;
   logic                  r_pend_v;

   logic [4*DIGITS-1:0]   w_acc_adj;
   logic [4*DIGITS-1:0]   w_acc_next;
   logic [WIDTH-1:0]      w_bin_next;
   logic                  w_last;
   logic                  w_unused_msb;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
      bcd_add3 u_add3 (
         .din  (r_acc[4*gi +: 4]),
         .dout (w_acc_adj[4*gi +: 4])
      );
   end

   // The corrected accumulator's MSB shifts out; it is always 0 for valid widths.
   assign w_acc_next   = {w_acc_adj[4*DIGITS-2:0], r_bin_sr[WIDTH-1]};
   assign w_bin_next   = {r_bin_sr[WIDTH-2:0], 1'b0};
   assign w_unused_msb = w_acc_adj[4*DIGITS-1];
   assign w_last       = (r_state == CONV) && (r_cnt == c_last);
   assign busy         = (r_state == CONV);

   always_ff @(posedge clk or negedge reset_a) begin
      if (!reset_a) begin
         r_state     <= IDLE;
         r_bin_sr    <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_pend_data <= '0;
         r_pend_v    <= 1'b0;
         bcd_out     <= '0;
         bcd_valid   <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         bcd_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (done_flag) begin
                  r_bin_sr <= product_in;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_state  <= CONV;
               end
            end
            default: begin
               r_acc    <= w_acc_next;
               r_bin_sr <= w_bin_next;
               r_cnt    <= r_cnt + 1'b1;
               if (w_last) begin
                  bcd_out   <= w_acc_next;
                  bcd_valid <= 1'b1;
                  // Pending entry has priority; a fresh product then refills the slot.
                  if (r_pend_v) begin
                     r_bin_sr <= r_pend_data;
                     r_acc    <= '0;
                     r_cnt    <= '0;
                     r_pend_v <= done_flag;
                     if (done_flag) begin
                        r_pend_data <= product_in;
                     end
                  end else if (done_flag) begin
                     r_bin_sr <= product_in;
                     r_acc    <= '0;
                     r_cnt    <= '0;
                  end else begin
                     r_state <= IDLE;
                  end
               end else if (done_flag) begin
                  r_pend_data <= product_in;
                  r_pend_v    <= 1'b1;
                  if (r_pend_v) begin
                     overrun <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

`ifdef PRODUCT_BCD_SEG_EN
   logic [7*DIGITS-1:0] w_seg_next;
   logic                w_lead;

   always_comb begin
      w_seg_next = '0;
      w_lead     = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (w_lead && (w_acc_next[4*i +: 4] == 4'd0)) begin
            w_seg_next[7*i +: 7] = SEG_BLANK;
         end else begin
            w_lead               = 1'b0;
            w_seg_next[7*i +: 7] = seg7_encode(w_acc_next[4*i +: 4]);
         end
      end
      w_seg_next[6:0] = seg7_encode(w_acc_next[3:0]);
   end

   always_ff @(posedge clk or negedge reset_a) begin
      if (!reset_a) begin
         seg_out <= {{(7*(DIGITS-1)){1'b0}}, seg7_encode(4'd0)};
      end else if (w_last) begin
         seg_out <= w_seg_next;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_product_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module : tb_product_bcd_conv
// Desc   : Scoreboard bench for product_bcd_conv with a transaction-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_product_bcd_conv;

   logic        clk = 1'b0;
   logic        reset_a = 1'b0;
   logic        done_flag = 1'b0;
   logic [15:0] product_in = '0;
   logic [19:0] bcd_out;
   logic        bcd_valid;
   logic        busy;
   logic        overrun;
`ifdef PRODUCT_BCD_SEG_EN
   logic [34:0] seg_out;
`endif

   product_bcd_conv #(.WIDTH(16), .DIGITS(5)) dut (
      .clk        (clk),
      .reset_a    (reset_a),
      .done_flag  (done_flag),
      .product_in (product_in),
      .bcd_out    (bcd_out),
      .bcd_valid  (bcd_valid),
      .busy       (busy),
      .overrun    (overrun)
`ifdef PRODUCT_BCD_SEG_EN
      ,
      .seg_out    (seg_out)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] bcd;
      logic [34:0] seg;
      int          due;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   // Transaction-level model state
   bit          m_busy = 0;
   int          m_end = 0;
   bit          m_pend_v = 0;
   logic [15:0] m_pend_val = '0;
   bit          m_overrun = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r = '0;
      int p = 1;
      for (int d = 0; d < 5; d++) begin
         r[4*d +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [6:0] seg_pat(input int d);
      case (d)
         0: return 7'b1111110;
         1: return 7'b0110000;
         2: return 7'b1101101;
         3: return 7'b1111001;
         4: return 7'b0110011;
         5: return 7'b1011011;
         6: return 7'b1011111;
         7: return 7'b1110000;
         8: return 7'b1111111;
         default: return 7'b1111011;
      endcase
   endfunction

   // Decimal digits below the number's length are shown, the rest blank.
   function automatic logic [34:0] seg_model(input int v);
      logic [34:0] s = '0;
      int n = 0;
      int t = v;
      int p = 1;
      while (t > 0) begin
         n++;
         t = t / 10;
      end
      if (n == 0) n = 1;
      for (int d = 0; d < 5; d++) begin
         if (d < n) s[7*d +: 7] = seg_pat((v / p) % 10);
         p = p * 10;
      end
      return s;
   endfunction

   function automatic void start_conv(input logic [15:0] v);
      exp_t e;
      e.bcd = to_bcd(int'(v));
      e.seg = seg_model(int'(v));
      e.due = cyc + 16;
      q.push_back(e);
      m_busy = 1;
      m_end  = cyc + 16;
   endfunction

   function automatic void model_edge(input logic df, input logic [15:0] v);
      if (m_busy && cyc == m_end) begin
         if (m_pend_v) begin
            start_conv(m_pend_val);
            m_pend_v = df;
            if (df) m_pend_val = v;
         end else if (df) begin
            start_conv(v);
         end else begin
            m_busy = 0;
         end
      end else if (m_busy) begin
         if (df) begin
            if (m_pend_v) m_overrun = 1;
            m_pend_v   = 1;
            m_pend_val = v;
         end
      end else if (df) begin
         start_conv(v);
      end
   endfunction

   function automatic void model_reset();
      m_busy    = 0;
      m_pend_v  = 0;
      m_overrun = 0;
      q.delete();
   endfunction

   task automatic tick(input logic df, input logic [15:0] v);
      done_flag  = df;
      product_in = v;
      @(posedge clk);
      #1;
      model_edge(df, v);
      check("busy", busy, m_busy);
      check("overrun", overrun, m_overrun);
      done_flag = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 16'h0000);
   endtask

   task automatic check_reset_outputs();
      check("rst_bcd_out", bcd_out, 20'h0);
      check("rst_bcd_valid", bcd_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_overrun", overrun, 1'b0);
`ifdef PRODUCT_BCD_SEG_EN
      check("rst_seg_out", seg_out, {28'h0, 7'b1111110});
`endif
   endtask

   task automatic async_reset();
      reset_a = 1'b0;
      #1;
      check_reset_outputs();
      model_reset();
      #2;
      reset_a = 1'b1;
   endtask

   // Monitor: every bcd_valid pulse must match the oldest expected result and its due edge.
   always @(negedge clk) begin
      if (reset_a && bcd_valid) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid: got bcd_out %0h, required no result (cycle %0d)", bcd_out, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("bcd_out", bcd_out, e.bcd);
            check("valid_edge", cyc, e.due);
`ifdef PRODUCT_BCD_SEG_EN
            check("seg_out", seg_out, e.seg);
`endif
         end
      end
   end

   initial begin
      #2;
      check_reset_outputs();
      #10;
      reset_a = 1'b1;

      // Maximum value
      tick(1'b1, 16'hFFFF);
      idle(20);
      // Zero
      tick(1'b1, 16'h0000);
      idle(20);
      // Pending buffer without overrun
      tick(1'b1, 16'h3039);
      idle(4);
      tick(1'b1, 16'h00FF);
      idle(40);
      // Pending overwrite sets overrun
      tick(1'b1, 16'h0001);
      idle(2);
      tick(1'b1, 16'h0002);
      idle(2);
      tick(1'b1, 16'h0003);
      idle(40);
      async_reset();
      // Reset mid-conversion discards the in-flight product
      tick(1'b1, 16'h1234);
      idle(8);
      async_reset();
      idle(3);
      tick(1'b1, 16'h002A);
      idle(20);
      // Capture exactly on the last iteration
      tick(1'b1, 16'h1111);
      idle(15);
      tick(1'b1, 16'h0064);
      idle(20);
      // Randomized traffic, including collisions and overwrites
      for (int n = 0; n < 200; n++) begin
         logic [15:0] v;
         int sel;
         sel = int'($urandom_range(0, 9));
         v = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : 16'($urandom);
         idle(int'($urandom_range(0, 24)));
         tick(1'b1, v);
      end
      idle(40);
      check("queue_drained", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
